hdmi_frame_writer: RTL

- Parametrised successor to the HDMI pixel address generator.
- Accepts the decoded HDMI pixel stream with DE/VSYNC and counts active pixels per frame.
- Maps each pixel to an SDRAM {bank,row,col} write address and queues each address+pixel pair in an internal FIFO.
- Presents the FIFO to the SDRAM controller via a valid/ready write port; all logic is on PIXCLK.

---
 rtl/hdmi_frame_writer_if.sv | 37 +++
 rtl/hdmi_frame_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_frame_writer_if.sv
// ============================================================================
// Module      : hdmi_frame_writer_if
// Description : SDRAM write port of the HDMI frame writer. Carries the head
//               entry of the write FIFO (bank/row/col/pixel) with a
//               valid/ready handshake.
//               master : frame writer (drives wr_valid/wr_bank/wr_row/
//                        wr_col/wr_data, samples wr_ready)
//               slave  : SDRAM controller (samples the entry, drives wr_ready)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hdmi_frame_writer_if #(
  parameter int PIX_W  = 24,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 13,
  parameter int BANK_W = 2
);
  logic              wr_valid;
  logic              wr_ready;
  logic [BANK_W-1:0] wr_bank;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    output wr_valid, wr_bank, wr_row, wr_col, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_bank, wr_row, wr_col, wr_data,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/hdmi_frame_writer.sv
// ============================================================================
// Module      : hdmi_frame_writer
// Description : Counts active HDMI pixels per frame, maps each one to an
//               SDRAM {bank,row,col} word address and queues address+pixel
//               in a first-word-fall-through FIFO drained over a
//               valid/ready write port. Everything runs on PIXCLK.
// Ports       : PIXCLK/RESET             clock, sync active-high reset
//               HDMI_RGB/DE/VSYNC        decoded pixel stream
//               enable                   capture enable, sampled at frame start
//               wr (master)              SDRAM write port (FIFO head)
//               frame_done               pulse after the last pixel is queued
//               overflow                 sticky pixel-dropped flag
//               fifo_level               FIFO occupancy
//               disp_frame               bank half of last completed frame
//                                        (HDMI_DOUBLE_BUFFER_EN only)
// Options     : `define HDMI_DOUBLE_BUFFER_EN to alternate bank halves
//               between consecutive frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_frame_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PIX_W      = 24,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 13,
  parameter int BANK_W     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic                          PIXCLK,
  input  wire logic                          RESET,
  input  wire logic [PIX_W-1:0]              HDMI_RGB,
  input  wire logic                          HDMI_DE,
  input  wire logic                          HDMI_VSYNC,
  input  wire logic                          enable,
  hdmi_frame_writer_if.master                wr,
  output logic                               frame_done,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
`ifdef HDMI_DOUBLE_BUFFER_EN
  ,
  output logic                               disp_frame
`endif
);

  localparam int AW = COL_W + ROW_W + BANK_W;
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = AW + PIX_W;

  localparam logic [XW-1:0] c_X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] c_FULL   = LW'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CAPTURE = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              vsync_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [AW-1:0]     lin_q, lin_d;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q;

  logic              w_frame_start;
  logic              w_pix_push;
  logic              w_full;
  logic              w_pop;
  logic              w_wr_en;
  logic [BANK_W-1:0] w_bank;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;

  assign w_frame_start = HDMI_VSYNC & ~vsync_q;

  // Frame sequencing. A VSYNC edge mid-capture abandons the frame and is
  // treated as the start of the next one in the same cycle; the pixel in
  // that cycle is not captured.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    lin_d      = lin_q;
    w_pix_push = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_frame_start && enable) state_d = c_CAPTURE;
      end
      c_CAPTURE: begin
        if (w_frame_start) begin
          x_d     = '0;
          y_d     = '0;
          lin_d   = '0;
          state_d = enable ? c_CAPTURE : c_IDLE;
        end else if (HDMI_DE) begin
          w_pix_push = 1'b1;
          // Advances even when the FIFO drops the pixel so later pixels
          // still land at their own frame position.
          lin_d      = lin_q + AW'(1);
          if (x_q == c_X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            if (y_q == c_Y_LAST) state_d = c_DONE;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      c_DONE: begin
        x_d     = '0;
        y_d     = '0;
        lin_d   = '0;
        state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      state_q <= c_IDLE;
      vsync_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      lin_q   <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= HDMI_VSYNC;
      x_q     <= x_d;
      y_q     <= y_d;
      lin_q   <= lin_d;
    end
  end

`ifdef HDMI_DOUBLE_BUFFER_EN
  logic sel_q;
  logic disp_q;

  // sel_q is the half being written; on completion it becomes the
  // displayable half and writing moves to the other one.
  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      sel_q  <= 1'b0;
      disp_q <= 1'b1;
    end else if (state_q == c_DONE) begin
      sel_q  <= ~sel_q;
      disp_q <= sel_q;
    end
  end

  always_comb begin
    w_bank             = lin_q[AW-1 -: BANK_W];
    w_bank[BANK_W-1]   = sel_q;
  end

  assign disp_frame = disp_q;
`else
  assign w_bank = lin_q[AW-1 -: BANK_W];
`endif

  assign w_entry = {w_bank, lin_q[COL_W+ROW_W-1:COL_W], lin_q[COL_W-1:0], HDMI_RGB};

  // FIFO: a push into a full FIFO is accepted only if the head leaves in
  // the same cycle; otherwise the pixel is lost and overflow latches.
  assign w_full  = (level_q == c_FULL);
  assign w_pop   = (level_q != '0) && wr.wr_ready;
  assign w_wr_en = w_pix_push && (!w_full || w_pop);
  assign level_d = level_q + LW'(w_wr_en) - LW'(w_pop);

  always_ff @(posedge PIXCLK) begin
    if (w_wr_en) mem_q[wptr_q] <= w_entry;
  end

  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (w_wr_en) wptr_q <= wptr_q + PW'(1);
      if (w_pop)   rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
      if (w_pix_push && w_full && !w_pop) ovf_q <= 1'b1;
    end
  end

  // Head is forced to zero while empty so stale storage never shows.
  assign w_head      = (level_q != '0) ? mem_q[rptr_q] : '0;
  assign wr.wr_valid = (level_q != '0);
  assign wr.wr_bank  = w_head[EW-1 -: BANK_W];
  assign wr.wr_row   = w_head[PIX_W+COL_W+ROW_W-1 -: ROW_W];
  assign wr.wr_col   = w_head[PIX_W+COL_W-1 -: COL_W];
  assign wr.wr_data  = w_head[PIX_W-1:0];

  assign frame_done = (state_q == c_DONE);
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

`default_nettype wire
